multicycle_control: RTL and testbench



---
 rtl/ctrl_pkg.sv | 105 ++++++++++
 rtl/inst_decode.sv | 108 ++++++++++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU/compare ops,
// immediate and writeback selects, FSM states, trap causes and the decoded control bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // Compare ops reuse the branch funct3 values directly.
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_PC4  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_FENCE, CLS_SYS
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] imm_sel;
    logic [1:0] alu_sel;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic       dmem_we;
    logic [1:0] dmem_bs;
    logic       dmem_se;
  } ctrl_t;

  function automatic logic [1:0] mem_bs(input logic [1:0] size);
    case (size)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // alt selects SUB / SRA; callers only raise it where funct7 legally encodes it.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational RV32I decoder: instruction word to control bundle plus an illegal flag.
module inst_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];

  always_comb begin
    ctrl         = '0;
    ctrl.cls     = CLS_ALU;
    ctrl.imm_sel = IMM_I;
    ctrl.alu_op  = ALU_ADD;
    illegal      = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.cls     = CLS_LOAD;
        ctrl.alu_sel = 2'b11;
        ctrl.wb_sel  = WB_LOAD;
        ctrl.rf_we   = 1'b1;
        ctrl.dmem_bs = mem_bs(funct3[1:0]);
        ctrl.dmem_se = ~funct3[2];
        illegal      = (funct3 == 3'b011) || (funct3[2] && funct3[1]);
      end
      OP_STORE: begin
        ctrl.cls     = CLS_STORE;
        ctrl.imm_sel = IMM_S;
        ctrl.alu_sel = 2'b11;
        ctrl.dmem_we = 1'b1;
        ctrl.dmem_bs = mem_bs(funct3[1:0]);
        illegal      = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_IMM: begin
        ctrl.alu_sel = 2'b11;
        ctrl.wb_sel  = WB_ALU;
        ctrl.rf_we   = 1'b1;
        ctrl.alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        illegal      = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                       ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OP_REG: begin
        ctrl.alu_sel = 2'b10;
        ctrl.wb_sel  = WB_ALU;
        ctrl.rf_we   = 1'b1;
        ctrl.alu_op  = alu_from_f3(funct3, funct7[5]);
        illegal      = !((funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_LUI: begin
        ctrl.imm_sel = IMM_U;
        ctrl.alu_sel = 2'b01;
        ctrl.alu_op  = ALU_PASS_B;
        ctrl.wb_sel  = WB_IMM;
        ctrl.rf_we   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.imm_sel = IMM_U;
        ctrl.alu_sel = 2'b01;
        ctrl.wb_sel  = WB_ALU;
        ctrl.rf_we   = 1'b1;
      end
      OP_JAL: begin
        ctrl.cls     = CLS_JUMP;
        ctrl.imm_sel = IMM_J;
        ctrl.alu_sel = 2'b01;
        ctrl.wb_sel  = WB_PC4;
        ctrl.rf_we   = 1'b1;
      end
      OP_JALR: begin
        ctrl.cls     = CLS_JUMP;
        ctrl.alu_sel = 2'b11;
        ctrl.wb_sel  = WB_PC4;
        ctrl.rf_we   = 1'b1;
        illegal      = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        ctrl.cls     = CLS_BRANCH;
        ctrl.imm_sel = IMM_B;
        ctrl.alu_sel = 2'b01;
        ctrl.cmp_op  = funct3;
        illegal      = (funct3[2:1] == 2'b01);
      end
      OP_FENCE: begin
        ctrl.cls = CLS_FENCE;
        illegal  = (funct3[2:1] != 2'b00);
      end
      OP_SYSTEM: begin
        // Only ECALL and EBREAK; CSR access is not supported by this core.
        ctrl.cls = CLS_SYS;
        illegal  = (inst != 32'h0000_0073) && (inst != 32'h0010_0073);
      end
      default: illegal = 1'b1;
    endcase
    if (rd == 5'd0) ctrl.rf_we = 1'b0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshakes with timeout, trap reporting and a retired-instruction counter.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      inst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             dmem_we,
  output logic [1:0]       dmem_bs,
  output logic             dmem_se,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_sel,
  output logic [3:0]       alu_op,
  output logic [2:0]       cmp_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        ir_q;
  ctrl_t              ctrl_q, dec_ctrl;
  logic               dec_illegal;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               trap_q;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   retired_q;
  logic               commit, wait_inc, set_trap, timeout_hit;
  logic [1:0]         set_cause;

  inst_decode u_decode (
    .inst    (ir_q),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Checked after the ack, so an ack landing on the last allowed cycle still wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_bs   = 2'b00;
    dmem_se   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel   = 3'b000;
    alu_sel   = 2'b00;
    alu_op    = 4'd0;
    cmp_op    = 3'b000;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    commit    = 1'b0;
    wait_inc  = 1'b0;
    set_trap  = 1'b0;
    set_cause = CAUSE_NONE;
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      imm_sel = ctrl_q.imm_sel;
      alu_sel = ctrl_q.alu_sel;
      alu_op  = ctrl_q.alu_op;
      cmp_op  = ctrl_q.cmp_op;
      wb_sel  = ctrl_q.wb_sel;
    end
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          set_trap  = 1'b1;
          set_cause = CAUSE_TIMEOUT;
          state_d   = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          set_trap  = 1'b1;
          set_cause = CAUSE_ILLEGAL;
          state_d   = S_HALT;
        end else if (dec_ctrl.cls == CLS_SYS) begin
          state_d = S_HALT;
        end else if (dec_ctrl.cls == CLS_FENCE) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ctrl_q.cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken;
            commit  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_q.dmem_we;
        dmem_bs  = ctrl_q.dmem_bs;
        dmem_se  = ctrl_q.dmem_se;
        if (dmem_ack) begin
          if (ctrl_q.cls == CLS_STORE) begin
            pc_we   = 1'b1;
            commit  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          set_trap  = 1'b1;
          set_cause = CAUSE_TIMEOUT;
          state_d   = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we   = ctrl_q.rf_we;
        pc_we   = 1'b1;
        pc_sel  = (ctrl_q.cls == CLS_JUMP);
        commit  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      ctrl_q     <= '0;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_inc ? wait_cnt_q + 1'b1 : '0;
      if (ir_we) ir_q <= inst;
      if (state_q == S_DECODE) ctrl_q <= dec_ctrl;
      if (set_trap) begin
        trap_q  <= 1'b1;
        cause_q <= set_cause;
      end
      if (commit) retired_q <= retired_q + 1'b1;
    end
  end

  assign halted     = (state_q == S_HALT);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of single instructions with
// hand-computed timing/control expectations, then hand-written trap, timeout and reset sequences.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic        clk, rst_n, start, imem_ack, dmem_ack, branch_taken;
  logic [31:0] inst;
  logic        imem_req, dmem_req, dmem_we, dmem_se, ir_we, pc_we, pc_sel, rf_we;
  logic        halted, trap;
  logic [1:0]  dmem_bs, alu_sel, wb_sel, trap_cause;
  logic [2:0]  imm_sel, cmp_op, dbg_state;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  // Narrow-counter instance driven by the same stimulus; only its counter is checked.
  logic        b_imem_req, b_dmem_req, b_dmem_we, b_dmem_se, b_ir_we, b_pc_we, b_pc_sel, b_rf_we;
  logic        b_halted, b_trap;
  logic [1:0]  b_dmem_bs, b_alu_sel, b_wb_sel, b_trap_cause;
  logic [2:0]  b_imm_sel, b_cmp_op, b_dbg_state;
  logic [3:0]  b_alu_op;
  logic [3:0]  b_retired;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .dmem_we(dmem_we), .dmem_bs(dmem_bs), .dmem_se(dmem_se), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_sel(alu_sel),
    .alu_op(alu_op), .cmp_op(cmp_op), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted),
    .trap(trap), .trap_cause(trap_cause), .retired(retired), .dbg_state(dbg_state)
  );

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst),
    .imem_req(b_imem_req), .imem_ack(imem_ack), .dmem_req(b_dmem_req), .dmem_ack(dmem_ack),
    .dmem_we(b_dmem_we), .dmem_bs(b_dmem_bs), .dmem_se(b_dmem_se), .branch_taken(branch_taken),
    .ir_we(b_ir_we), .pc_we(b_pc_we), .pc_sel(b_pc_sel), .imm_sel(b_imm_sel), .alu_sel(b_alu_sel),
    .alu_op(b_alu_op), .cmp_op(b_cmp_op), .rf_we(b_rf_we), .wb_sel(b_wb_sel), .halted(b_halted),
    .trap(b_trap), .trap_cause(b_trap_cause), .retired(b_retired), .dbg_state(b_dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1);
  end

  // Driver and checking tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    branch_taken = 1'b0; inst = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH with zero-wait imem and dly wait cycles on dmem.
  task automatic run_instr(input logic [31:0] i_inst, input int dly, input logic bt,
                           output int cycles, output int rfw_n, output int dreq_n,
                           output int pcwe_n, output int irwe_n,
                           output logic [1:0] wb_o, output logic [3:0] alu_o,
                           output logic [2:0] imm_o, output logic pcs_o,
                           output logic [1:0] bs_o, output logic we_o, output logic se_o);
    int mem_wait;
    cycles = 0; rfw_n = 0; dreq_n = 0; pcwe_n = 0; irwe_n = 0; mem_wait = 0;
    wb_o = 2'b00; alu_o = 4'hF; imm_o = 3'b111; pcs_o = 1'b0;
    bs_o = 2'b00; we_o = 1'b0; se_o = 1'b0;
    do begin
      inst         = i_inst;
      branch_taken = bt;
      imem_ack     = (dbg_state == S_FETCH);
      dmem_ack     = (dbg_state == S_MEM) && (mem_wait == dly);
      #1;
      cycles++;
      if (ir_we) irwe_n++;
      if (rf_we) begin rfw_n++; wb_o = wb_sel; alu_o = alu_op; end
      if (dmem_req) begin dreq_n++; bs_o = dmem_bs; we_o = dmem_we; se_o = dmem_se; end
      if (pc_we) begin pcwe_n++; pcs_o = pc_sel; end
      if (dbg_state == S_EXEC) imm_o = imm_sel;
      if (dbg_state == S_MEM) mem_wait++;
      @(negedge clk);
    end while (dbg_state != S_FETCH && dbg_state != S_HALT && cycles < 64);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    int          dly;
    logic        bt;
    int          cyc;
    int          rfw;
    int          dreq;
    logic [1:0]  wb;
    logic [3:0]  alu;
    logic [2:0]  imm;
    logic        pcs;
    logic [1:0]  bs;
    logic        we;
    logic        se;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int cyc, rfw, dreq, pcwe, irwe, req_n, n;
    logic [1:0] wb_o, bs_o;
    logic [3:0] alu_o;
    logic [2:0] imm_o;
    logic pcs_o, we_o, se_o;
    logic [31:0] exp_ret;

    //            inst          dly bt   cyc rfw dreq wb       alu         imm    pcs   bs     we    se
    vecs[0]  = '{32'h00500093, 0,  1'b0, 4,  1,  0,   WB_ALU,  ALU_ADD,    IMM_I, 1'b0, 2'b00, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h0000A103, 3,  1'b0, 8,  1,  4,   WB_LOAD, ALU_ADD,    IMM_I, 1'b0, 2'b11, 1'b0, 1'b1}; // lw, 3 waits
    vecs[2]  = '{32'h0000A103, 0,  1'b0, 5,  1,  1,   WB_LOAD, ALU_ADD,    IMM_I, 1'b0, 2'b11, 1'b0, 1'b1}; // lw, 0 waits
    vecs[3]  = '{32'h0000A103, 15, 1'b0, 20, 1,  16,  WB_LOAD, ALU_ADD,    IMM_I, 1'b0, 2'b11, 1'b0, 1'b1}; // ack on timeout cycle
    vecs[4]  = '{32'h0020A223, 0,  1'b0, 4,  0,  1,   WB_PC4,  ALU_ADD,    IMM_S, 1'b0, 2'b11, 1'b1, 1'b0}; // sw
    vecs[5]  = '{32'h0000C183, 0,  1'b0, 5,  1,  1,   WB_LOAD, ALU_ADD,    IMM_I, 1'b0, 2'b01, 1'b0, 1'b0}; // lbu
    vecs[6]  = '{32'h00009183, 1,  1'b0, 6,  1,  2,   WB_LOAD, ALU_ADD,    IMM_I, 1'b0, 2'b10, 1'b0, 1'b1}; // lh, 1 wait
    vecs[7]  = '{32'h00208463, 0,  1'b1, 3,  0,  0,   WB_PC4,  ALU_ADD,    IMM_B, 1'b1, 2'b00, 1'b0, 1'b0}; // beq taken
    vecs[8]  = '{32'h00208463, 0,  1'b0, 3,  0,  0,   WB_PC4,  ALU_ADD,    IMM_B, 1'b0, 2'b00, 1'b0, 1'b0}; // beq not taken
    vecs[9]  = '{32'h402082B3, 0,  1'b0, 4,  1,  0,   WB_ALU,  ALU_SUB,    IMM_I, 1'b0, 2'b00, 1'b0, 1'b0}; // sub
    vecs[10] = '{32'h12345337, 0,  1'b0, 4,  1,  0,   WB_IMM,  ALU_PASS_B, IMM_U, 1'b0, 2'b00, 1'b0, 1'b0}; // lui
    vecs[11] = '{32'h010000EF, 0,  1'b0, 4,  1,  0,   WB_PC4,  ALU_ADD,    IMM_J, 1'b1, 2'b00, 1'b0, 1'b0}; // jal x1,16
    vecs[12] = '{32'h00000013, 0,  1'b0, 4,  0,  0,   WB_PC4,  ALU_ADD,    IMM_I, 1'b0, 2'b00, 1'b0, 1'b0}; // nop (rd=x0)
    vecs[13] = '{32'h0000000F, 0,  1'b0, 3,  0,  0,   WB_PC4,  ALU_ADD,    3'b111, 1'b0, 2'b00, 1'b0, 1'b0}; // fence skips EXEC
    vecs[14] = '{32'hFFF0C393, 0,  1'b0, 4,  1,  0,   WB_ALU,  ALU_XOR,    IMM_I, 1'b0, 2'b00, 1'b0, 1'b0}; // xori -1
    vecs[15] = '{32'h000100E7, 0,  1'b0, 4,  1,  0,   WB_PC4,  ALU_ADD,    IMM_I, 1'b1, 2'b00, 1'b0, 1'b0}; // jalr
    vecs[16] = '{32'h00000013, 0,  1'b0, 4,  0,  0,   WB_PC4,  ALU_ADD,    IMM_I, 1'b0, 2'b00, 1'b0, 1'b0}; // nop, 17th commit

    // Reset state, with stray acks and no start
    do_reset();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    check("reset state", dbg_state, S_IDLE);
    check("reset strobes", {imem_req, dmem_req, ir_we, pc_we, rf_we, dmem_we}, 6'b0);
    check("reset status", {halted, trap, trap_cause}, 4'b0);
    check("reset retired", retired, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("idle without start", dbg_state, S_IDLE);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    pulse_start();
    check("fetch after start", dbg_state, S_FETCH);

    // Table of single instructions, back to back
    for (int i = 0; i < 17; i++) exp_q.push_back(32'(i + 1));
    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].inst, vecs[i].dly, vecs[i].bt, cyc, rfw, dreq, pcwe, irwe,
                wb_o, alu_o, imm_o, pcs_o, bs_o, we_o, se_o);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d rf_we count", i), rfw, vecs[i].rfw);
      check($sformatf("v%0d dmem_req cycles", i), dreq, vecs[i].dreq);
      check($sformatf("v%0d pc_we count", i), pcwe, 1);
      check($sformatf("v%0d ir_we count", i), irwe, 1);
      check($sformatf("v%0d pc_sel", i), pcs_o, vecs[i].pcs);
      check($sformatf("v%0d imm_sel", i), imm_o, vecs[i].imm);
      if (vecs[i].rfw > 0) begin
        check($sformatf("v%0d wb_sel", i), wb_o, vecs[i].wb);
        check($sformatf("v%0d alu_op", i), alu_o, vecs[i].alu);
      end
      if (vecs[i].dreq > 0) begin
        check($sformatf("v%0d dmem_bs", i), bs_o, vecs[i].bs);
        check($sformatf("v%0d dmem_we", i), we_o, vecs[i].we);
        check($sformatf("v%0d dmem_se", i), se_o, vecs[i].se);
      end
      exp_ret = exp_q.pop_front();
      check($sformatf("v%0d retired", i), retired, exp_ret);
      check($sformatf("v%0d retired cnt4", i), b_retired, exp_ret & 32'hF);
    end
    check("cnt4 wrapped after 17", b_retired, 32'd1);

    // Illegal instruction traps without retiring, and HALT ignores everything
    run_instr(32'hFFFFFFFF, 0, 1'b0, cyc, rfw, dreq, pcwe, irwe,
              wb_o, alu_o, imm_o, pcs_o, bs_o, we_o, se_o);
    check("illegal cycles", cyc, 2);
    check("illegal no commit", pcwe, 0);
    check("illegal halted", halted, 1'b1);
    check("illegal trap", trap, 1'b1);
    check("illegal cause", trap_cause, CAUSE_ILLEGAL);
    check("illegal retired", retired, 32'd17);
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("halt terminal", dbg_state, S_HALT);
    check("halt strobes", {imem_req, dmem_req, ir_we, pc_we, rf_we}, 5'b0);
    @(negedge clk);

    // ECALL halts cleanly
    do_reset();
    pulse_start();
    run_instr(32'h00000073, 0, 1'b0, cyc, rfw, dreq, pcwe, irwe,
              wb_o, alu_o, imm_o, pcs_o, bs_o, we_o, se_o);
    check("ecall halted", halted, 1'b1);
    check("ecall trap", {trap, trap_cause}, 3'b000);
    check("ecall retired", retired, 32'd0);

    // Fetch timeout with imem_ack never asserted
    do_reset();
    pulse_start();
    req_n = 0; n = 0;
    while (dbg_state != S_HALT && n < 64) begin
      imem_ack = 1'b0;
      #1;
      if (imem_req) req_n++;
      n++;
      @(negedge clk);
    end
    #1;
    check("timeout req cycles", req_n, 16);
    check("timeout halted", halted, 1'b1);
    check("timeout trap", trap, 1'b1);
    check("timeout cause", trap_cause, CAUSE_TIMEOUT);
    check("timeout req dropped", imem_req, 1'b0);

    // Asynchronous reset in the middle of a load's MEM phase
    @(negedge clk);
    do_reset();
    pulse_start();
    inst = 32'h0000A103;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("mid-mem state", dbg_state, S_MEM);
    check("mid-mem dmem_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset dmem_req", dmem_req, 1'b0);
    check("async reset state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post-reset idle", dbg_state, S_IDLE);
    check("post-reset retired", retired, 32'd0);
    @(negedge clk);
    pulse_start();
    check("refetch after start", dbg_state, S_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
